// File: rtl/game_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_controller_if : control, status and board-read signals of the game
// Rev 1.0
// ---------------------------------------------------------------------------
interface game_controller_if;
  logic       start;
  logic       drop;
  logic [2:0] col_sel;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [1:0] rd_data;
  logic [1:0] state;
  logic [1:0] game_status;
  logic       move_ack;
  logic       move_reject;
  logic       busy;

  modport master (
    output start, drop, col_sel, rd_row, rd_col,
    input  rd_data, state, game_status, move_ack, move_reject, busy
  );

  modport slave (
    input  start, drop, col_sel, rd_row, rd_col,
    output rd_data, state, game_status, move_ack, move_reject, busy
  );
endinterface
`default_nettype wire

// File: rtl/game_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_controller : Connect-4 sequencer with board store, move validation
//                   and a one-neighbour-per-cycle win/tie checker
// Rev 1.0
// ---------------------------------------------------------------------------
module game_controller #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  game_controller_if.slave bus
);
  typedef enum logic [1:0] {
    GAME_INIT = 2'b00,
    P1_TURN   = 2'b01,
    P2_TURN   = 2'b10,
    END_GAME  = 2'b11
  } state_t;

  localparam int                CELLS   = ROWS * COLS;
  localparam logic [2:0]        ROWS_U  = ROWS[2:0];
  localparam logic [2:0]        COLS_U  = COLS[2:0];
  localparam logic [2:0]        WIN_U   = WIN_LEN[2:0];
  localparam logic [5:0]        CELLS_U = CELLS[5:0];
  localparam logic signed [4:0] ROWS_S  = {2'b00, ROWS_U};
  localparam logic signed [4:0] COLS_S  = {2'b00, COLS_U};

  state_t            r_state;
  logic [1:0]        r_status;
  logic              r_ack;
  logic              r_rej;
  logic              r_busy;
  logic [1:0]        r_board [ROWS][COLS];
  logic [2:0]        r_height [COLS];
  logic [5:0]        r_moves;
  logic signed [4:0] r_pr, r_pc, r_cr, r_cc;
  logic [1:0]        r_dir;
  logic              r_neg;
  logic [2:0]        r_run;

  logic [1:0]        w_code, w_nb, w_rd;
  logic              w_start_ok, w_in_play, w_col_ok, w_full;
  logic              w_in_bounds, w_match, w_win_step;
  logic [2:0]        w_sel_h, w_run_nx;
  logic signed [4:0] w_dr, w_dc, w_nr, w_nc;

  always_comb begin
    w_code     = (r_state == P2_TURN) ? 2'b10 : 2'b01;
    w_start_ok = bus.start && (r_state == GAME_INIT || r_state == END_GAME);
    w_in_play  = (r_state == P1_TURN) || (r_state == P2_TURN);
    w_col_ok   = bus.col_sel < COLS_U;
    w_sel_h    = w_col_ok ? r_height[bus.col_sel] : 3'd0;
    w_full     = (w_sel_h == ROWS_U);

    // Positive sense of each direction; the negative sense mirrors it.
    w_dr = 5'sd0;
    w_dc = 5'sd0;
    case (r_dir)
      2'd0:    begin w_dr = 5'sd0; w_dc = 5'sd1;  end
      2'd1:    begin w_dr = 5'sd1; w_dc = 5'sd0;  end
      2'd2:    begin w_dr = 5'sd1; w_dc = 5'sd1;  end
      default: begin w_dr = 5'sd1; w_dc = -5'sd1; end
    endcase
    if (r_neg) begin
      w_dr = -w_dr;
      w_dc = -w_dc;
    end
    w_nr        = r_cr + w_dr;
    w_nc        = r_cc + w_dc;
    w_in_bounds = (w_nr >= 5'sd0) && (w_nr < ROWS_S) && (w_nc >= 5'sd0) && (w_nc < COLS_S);
    w_nb        = 2'b00;
    if (w_in_bounds) w_nb = r_board[w_nr[2:0]][w_nc[2:0]];
    w_match     = w_in_bounds && (w_nb == w_code);
    w_run_nx    = r_run + 3'd1;
    w_win_step  = w_match && (w_run_nx >= WIN_U);

    w_rd = 2'b00;
    if (bus.rd_row < ROWS_U && bus.rd_col < COLS_U) w_rd = r_board[bus.rd_row][bus.rd_col];
  end

  assign bus.rd_data     = w_rd;
  assign bus.state       = r_state;
  assign bus.game_status = r_status;
  assign bus.move_ack    = r_ack;
  assign bus.move_reject = r_rej;
  assign bus.busy        = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= GAME_INIT;
      r_status <= 2'b00;
      r_ack    <= 1'b0;
      r_rej    <= 1'b0;
      r_busy   <= 1'b0;
      r_moves  <= 6'd0;
      r_pr     <= 5'sd0;
      r_pc     <= 5'sd0;
      r_cr     <= 5'sd0;
      r_cc     <= 5'sd0;
      r_dir    <= 2'd0;
      r_neg    <= 1'b0;
      r_run    <= 3'd1;
      for (int c = 0; c < COLS; c++) begin
        r_height[c] <= 3'd0;
        for (int r = 0; r < ROWS; r++) r_board[r][c] <= 2'b00;
      end
    end else begin
      r_ack <= 1'b0;
      r_rej <= 1'b0;
      if (w_start_ok) begin
        r_state  <= P1_TURN;
        r_status <= 2'b00;
        r_moves  <= 6'd0;
        for (int c = 0; c < COLS; c++) begin
          r_height[c] <= 3'd0;
          for (int r = 0; r < ROWS; r++) r_board[r][c] <= 2'b00;
        end
      end else if (r_busy) begin
        if (w_win_step) begin
          r_busy   <= 1'b0;
          r_state  <= END_GAME;
          r_status <= w_code;
        end else if (w_match) begin
          r_run <= w_run_nx;
          r_cr  <= w_nr;
          r_cc  <= w_nc;
        end else if (!r_neg) begin
          r_neg <= 1'b1;
          r_cr  <= r_pr;
          r_cc  <= r_pc;
        end else if (r_dir != 2'd3) begin
          r_dir <= r_dir + 2'd1;
          r_neg <= 1'b0;
          r_run <= 3'd1;
          r_cr  <= r_pr;
          r_cc  <= r_pc;
        end else begin
          r_busy <= 1'b0;
          if (r_moves == CELLS_U) begin
            r_state  <= END_GAME;
            r_status <= 2'b11;
          end else begin
            r_state <= (r_state == P1_TURN) ? P2_TURN : P1_TURN;
          end
        end
      end else if (bus.drop && w_in_play) begin
        if (!w_col_ok || w_full) begin
          r_rej <= 1'b1;
        end else begin
          r_board[w_sel_h][bus.col_sel] <= w_code;
          r_height[bus.col_sel]         <= w_sel_h + 3'd1;
          r_moves <= r_moves + 6'd1;
          r_ack   <= 1'b1;
          r_busy  <= 1'b1;
          r_pr    <= {2'b00, w_sel_h};
          r_pc    <= {2'b00, bus.col_sel};
          r_cr    <= {2'b00, w_sel_h};
          r_cc    <= {2'b00, bus.col_sel};
          r_dir   <= 2'd0;
          r_neg   <= 1'b0;
          r_run   <= 3'd1;
        end
      end
    end
  end
endmodule
`default_nettype wire
